// File: rtl/bnn_pkg.sv
// bnn_pkg: shared fixed-point types, FSM states and saturation helper for the binary-weight layers.
package bnn_pkg;
   localparam int BIT_CNT    = 8;
   localparam int OUTPUT_DIM = 4;
   localparam int FRAC_BITS  = 6;
   localparam int ACC_W      = BIT_CNT + $clog2(OUTPUT_DIM) + 1;

   typedef logic signed [BIT_CNT-1:0] fixed_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef enum logic {ACCUM, DONE} state_t;
   typedef struct packed {
      fixed_t val;
      logic   clamped;
   } sat_t;

   localparam fixed_t FIX_MAX = fixed_t'(2**(BIT_CNT-1) - 1);
   localparam fixed_t FIX_MIN = fixed_t'(-(2**(BIT_CNT-1)));
   localparam acc_t   ACC_MAX = acc_t'(FIX_MAX);
   localparam acc_t   ACC_MIN = acc_t'(FIX_MIN);

   function automatic sat_t sat_to_fixed(input acc_t a);
      sat_t r;
      r.clamped = (a > ACC_MAX) || (a < ACC_MIN);
      r.val     = a > ACC_MAX ? FIX_MAX : a < ACC_MIN ? FIX_MIN : fixed_t'(a);
      return r;
   endfunction
endpackage

// File: rtl/bwb_lane.sv
// bwb_lane: one signed accumulator lane, adds or subtracts the row gradient by weight bit and saturates.
module bwb_lane
   import bnn_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   clr,
   input  logic   w,
   input  fixed_t grad,
   output fixed_t val,
   output logic   sat
);
   acc_t acc;
   acc_t g;
   sat_t s;
   // widen before negating so the most negative gradient negates exactly
   assign g   = acc_t'(grad);
   assign s   = sat_to_fixed(acc);
   assign val = s.val;
   assign sat = s.clamped;

   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (en)    acc <= w ? acc + g : acc - g;
   end
endmodule

// File: rtl/bin_weight_backprop.sv
// bin_weight_backprop: grad_in = W^T * grad_out over OUTPUT_DIM streamed rows, saturated per lane.
// Optional BWB_STE_MASK_EN adds act_in and zeroes lanes whose activation magnitude exceeds 1.0.
module bin_weight_backprop
   import bnn_pkg::*;
#(
   parameter int INPUT_DIM = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [BIT_CNT-1:0]    grad_out,
   input  logic [INPUT_DIM-1:0]         weight_row,
`ifdef BWB_STE_MASK_EN
   input  logic [INPUT_DIM*BIT_CNT-1:0] act_in,
`endif
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INPUT_DIM*BIT_CNT-1:0] grad_in,
   output logic [INPUT_DIM-1:0]         sat_flags
);
   localparam int ROW_W = $clog2(OUTPUT_DIM);

   state_t           state, state_next;
   logic [ROW_W-1:0] row_cnt;
   logic             beat, last, clr;
   logic [INPUT_DIM-1:0] mask, sat;
   fixed_t           val [INPUT_DIM];

   always_comb begin
      state_next = state;
      in_ready   = state == ACCUM;
      out_valid  = state == DONE;
      beat       = in_valid && in_ready;
      last       = beat && row_cnt == ROW_W'(OUTPUT_DIM - 1);
      clr        = out_valid && out_ready;
      state_next = last ? DONE : clr ? ACCUM : state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ACCUM;
         row_cnt <= '0;
      end else begin
         state   <= state_next;
         if (beat) row_cnt <= last ? '0 : row_cnt + 1'b1;
      end
   end

`ifdef BWB_STE_MASK_EN
   localparam fixed_t FIX_ONE = fixed_t'(2**FRAC_BITS);
   logic [INPUT_DIM*BIT_CNT-1:0] act_q;

   // activations belong to the whole result, so capture them with the first row
   always_ff @(posedge clk) begin
      if (rst)                     act_q <= '0;
      else if (beat && row_cnt == '0) act_q <= act_in;
   end
`else
   assign mask = '0;
`endif

   for (genvar j = 0; j < INPUT_DIM; j++) begin : g_lane
      bwb_lane u_lane (
         .clk  (clk),
         .rst  (rst),
         .en   (beat),
         .clr  (clr),
         .w    (weight_row[j]),
         .grad (grad_out),
         .val  (val[j]),
         .sat  (sat[j])
      );
`ifdef BWB_STE_MASK_EN
      fixed_t a;
      assign a       = act_q[j*BIT_CNT +: BIT_CNT];
      assign mask[j] = a > FIX_ONE || a < -FIX_ONE;
`endif
      assign grad_in[j*BIT_CNT +: BIT_CNT] = mask[j] ? '0 : val[j];
      assign sat_flags[j] = sat[j] && !mask[j];
   end
endmodule

// File: tb/tb_bin_weight_backprop.sv
// tb_bin_weight_backprop: directed vectors with hand-computed gradients for bin_weight_backprop.
module tb_bin_weight_backprop;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  grad_out, weight_row, sat_flags;
   logic [63:0] grad_in;
`ifdef BWB_STE_MASK_EN
   logic [63:0] act_in = '0;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bin_weight_backprop dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .grad_out   (grad_out),
      .weight_row (weight_row),
`ifdef BWB_STE_MASK_EN
      .act_in     (act_in),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .grad_in    (grad_in),
      .sat_flags  (sat_flags)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] g, input logic [7:0] w);
      grad_out   = g;
      weight_row = w;
      in_valid   = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic [63:0] g, input logic [7:0] s);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_grad"}, grad_in, g);
      chk({tag, "_sat"}, 64'(sat_flags), 64'(s));
   endtask

   task automatic ack(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, "_ack_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ack_ready"}, 64'(in_ready), 64'd1);
   endtask

   function automatic logic [63:0] rep(input logic [7:0] v);
      return {8{v}};
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; grad_out = '0; weight_row = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_grad", grad_in, 64'd0);
      chk("rst_sat", 64'(sat_flags), 64'd0);

      repeat (3) beat(8'd10, 8'hFF);
      chk("t1_early", 64'(out_valid), 64'd0);
      beat(8'd10, 8'hFF);
      result("t1", rep(8'd40), 8'h00);
      ack("t1");

      beat(8'd10, 8'h0F); beat(8'd10, 8'h0F); beat(8'hFB, 8'h0F); beat(8'd3, 8'h0F);
      result("t2", {{4{8'hEE}}, {4{8'h12}}}, 8'h00);
      ack("t2");

      repeat (4) beat(8'h80, 8'hFF);
      result("t3_neg", rep(8'h80), 8'hFF);
      ack("t3_neg");
      repeat (4) beat(8'h80, 8'h00);
      result("t3_pos", rep(8'h7F), 8'hFF);

      grad_out = 8'd50; weight_row = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("t4_hold_grad", grad_in, rep(8'h7F));
         chk("t4_hold_valid", 64'(out_valid), 64'd1);
         chk("t4_hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      ack("t4");
      repeat (4) beat(8'd2, 8'hFF);
      result("t4_new", rep(8'd8), 8'h00);
      ack("t4_new");

      repeat (2) beat(8'd20, 8'hFF);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_grad", grad_in, 64'd0);
      chk("t5_ready", 64'(in_ready), 64'd1);
      repeat (3) beat(8'd1, 8'hFF);
      chk("t5_early", 64'(out_valid), 64'd0);
      beat(8'd1, 8'hFF);
      result("t5", rep(8'd4), 8'h00);
      ack("t5");

`ifdef BWB_STE_MASK_EN
      act_in = {{5{8'h20}}, 8'h50, {2{8'h20}}};
      repeat (4) beat(8'd10, 8'hFF);
      result("t6", {{5{8'd40}}, 8'd0, {2{8'd40}}}, 8'h00);
      ack("t6");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
